ebrick_umi_mem: RTL and testbench
=================================

EBRICK_UMI_MEM -- requirements
Module: ebrick_umi_mem

Interface
REQ-001 SHALL have parameters: DW 32 (data width, bits); AW 64 (address width); CW 32 (command width); DEPTH 1024 (storage words of DW bits); BASE 64'h0 (first byte address served).
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- udev_req_valid  in  1  request valid
- udev_req_cmd  in  CW  UMI command
- udev_req_dstaddr  in  AW  target byte address
- udev_req_srcaddr  in  AW  requester return address
- udev_req_data  in  DW  write data, LSB-aligned
- udev_req_ready  out  1  request accepted when high with valid
- udev_resp_valid  out  1  response valid
- udev_resp_cmd  out  CW  response command
- udev_resp_dstaddr  out  AW  equals request srcaddr
- udev_resp_srcaddr  out  AW  equals request dstaddr
- udev_resp_data  out  DW  read data, LSB-aligned
- udev_resp_ready  in  1  response consumed when high with valid
- err_count  out  8  saturating count of rejected requests

Function
REQ-004 SHALL be the UMI device answering a UMI host port; a request transfers on a rising edge where udev_req_valid and udev_req_ready are both high.
REQ-005 SHALL implement FSM states IDLE and RESP; udev_req_ready SHALL be high only in IDLE and while reset is low.
REQ-006 IDLE: on an accepted REQ_READ or REQ_WRITE, go to RESP next cycle; on an accepted REQ_POSTED or unsupported opcode, stay in IDLE.
REQ-007 RESP: udev_resp_valid high; all udev_resp_* held stable until udev_resp_ready is high; then return to IDLE with udev_resp_valid low on the next cycle.
REQ-008 Latency: response valid exactly 1 cycle after acceptance; throughput is 1 request per 2 cycles with udev_resp_ready tied high; posted writes run 1 per cycle.
REQ-009 Decode: opcode cmd[4:0], size cmd[7:5], len cmd[15:8]; REQ_READ=0x01, REQ_WRITE=0x03, REQ_POSTED=0x05, RESP_READ=0x02, RESP_WRITE=0x04.
REQ-010 Legal request: len==0; size <= log2(DW/8); dstaddr aligned to 2^size bytes; BASE <= dstaddr < BASE+DEPTH*DW/8.
REQ-011 Word index = (dstaddr-BASE)/(DW/8); byte offset = (dstaddr-BASE) mod (DW/8).
REQ-012 Legal write/posted: update only the 2^size bytes starting at the byte offset, from udev_req_data LSBs; all other bytes unchanged.
REQ-013 Legal read: udev_resp_data = the 2^size bytes at the offset, shifted to LSBs; upper bytes zero.
REQ-014 Response cmd: opcode RESP_READ for a read, RESP_WRITE for a write; size and len copied from the request; all other bits zero.
REQ-015 Illegal read/write (REQ-010 fails): no memory change; response still issued with data zero; err_count increments.
REQ-016 Illegal posted write or unsupported opcode: consumed, no response, no memory change, err_count increments.
REQ-017 err_count saturates at 255.
REQ-018 Storage is written only by legal writes; a read in the cycle after a write to the same word returns the new data.

Reset
REQ-019 While reset is high: state IDLE, udev_resp_valid 0, all udev_resp_* 0, udev_req_ready 0, err_count 0.
REQ-020 Reset during RESP drops the pending response; storage contents are retained across reset and undefined after power-up.

Structure
REQ-021 SHALL use shared package ebrick_umi_mem_pkg holding the opcode constants, cmd field positions/widths, and the state enum.
REQ-022 SHALL use one sub-module, ebrick_umi_mem_decode: a combinational cmd/address legality decoder producing opcode, size, byte mask and legal flag.

Verification
REQ-023 WRITE 0x3 size2 dst 0x10 data 0xDEADBEEF, then READ size2 0x10 -> RESP_WRITE, then RESP_READ data 0xDEADBEEF; dstaddr/srcaddr swapped.
REQ-024 POSTED size0 dst 0x11 data 0xAA after REQ-023, then READ size2 0x10 -> no response to the posted write; read returns 0xDEADAAEF.
REQ-025 udev_resp_ready low 5 cycles during a read -> resp fields stable; udev_req_ready low for all 5 cycles.
REQ-026 READ dst 0x1000 (DEPTH 1024), READ size2 at 0x12, opcode 0x09 -> responses with data 0 for the first two, none for the third; err_count = 3.
REQ-027 reset asserted while in RESP -> udev_resp_valid 0 in the same cycle; after reset deassertion, READ 0x10 still returns the previously written data.
REQ-028 300 unsupported requests -> err_count = 255.

Source files
------------

// File: rtl/ebrick_umi_mem_pkg.sv
// Shared definitions for the UMI memory device: command field layout,
// opcodes, FSM states and the response command packer.
package ebrick_umi_mem_pkg;

    localparam int OPC_LSB  = 0;
    localparam int OPC_W    = 5;
    localparam int SIZE_LSB = 5;
    localparam int SIZE_W   = 3;
    localparam int LEN_LSB  = 8;
    localparam int LEN_W    = 8;

    localparam logic [OPC_W-1:0] REQ_READ   = 5'h01;
    localparam logic [OPC_W-1:0] RESP_READ  = 5'h02;
    localparam logic [OPC_W-1:0] REQ_WRITE  = 5'h03;
    localparam logic [OPC_W-1:0] RESP_WRITE = 5'h04;
    localparam logic [OPC_W-1:0] REQ_POSTED = 5'h05;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // Response commands carry only opcode, size and len; everything above is zero.
    function automatic logic [LEN_LSB+LEN_W-1:0] packRespCmd(
        input logic [OPC_W-1:0]  opc,
        input logic [SIZE_W-1:0] size,
        input logic [LEN_W-1:0]  len
    );
        return {len, size, opc};
    endfunction

endpackage

// File: rtl/ebrick_umi_mem_if.sv
// UMI device port bundle: request channel from the host, response channel back.
interface ebrick_umi_mem_if #(
    parameter int DW = 32,
    parameter int AW = 64,
    parameter int CW = 32
);
    logic          udev_req_valid;
    logic [CW-1:0] udev_req_cmd;
    logic [AW-1:0] udev_req_dstaddr;
    logic [AW-1:0] udev_req_srcaddr;
    logic [DW-1:0] udev_req_data;
    logic          udev_req_ready;

    logic          udev_resp_valid;
    logic [CW-1:0] udev_resp_cmd;
    logic [AW-1:0] udev_resp_dstaddr;
    logic [AW-1:0] udev_resp_srcaddr;
    logic [DW-1:0] udev_resp_data;
    logic          udev_resp_ready;

    modport master (
        output udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr, udev_req_data,
        input  udev_req_ready,
        input  udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr, udev_resp_srcaddr, udev_resp_data,
        output udev_resp_ready
    );

    modport slave (
        input  udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr, udev_req_data,
        output udev_req_ready,
        output udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr, udev_resp_srcaddr, udev_resp_data,
        input  udev_resp_ready
    );
endinterface

// File: rtl/ebrick_umi_mem_decode.sv
// Combinational decoder: splits a UMI command and checks whether the access
// fits the memory (len, size, alignment, address window).
module ebrick_umi_mem_decode
    import ebrick_umi_mem_pkg::*;
#(
    parameter int            DW    = 32,
    parameter int            AW    = 64,
    parameter int            CW    = 32,
    parameter int            DEPTH = 1024,
    parameter logic [AW-1:0] BASE  = '0,
    localparam int           NB    = DW / 8,
    localparam int           OB    = $clog2(NB),
    localparam int           IW    = $clog2(DEPTH)
) (
    input  logic [CW-1:0]     i_cmd,
    input  logic [AW-1:0]     i_dstaddr,
    output logic [OPC_W-1:0]  o_opcode,
    output logic [SIZE_W-1:0] o_size,
    output logic [LEN_W-1:0]  o_len,
    output logic [IW-1:0]     o_index,
    output logic [OB-1:0]     o_offset,
    output logic [NB-1:0]     o_bytemask,
    output logic              o_legal
);

    localparam logic [AW-1:0]     SPAN     = AW'(DEPTH * NB);
    localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(OB);

    logic          w_borrow;
    logic [AW-1:0] w_rel;
    logic [AW-1:0] w_alignMask;
    logic          w_inRange;
    logic          w_aligned;
    int            w_off;
    int            w_nbytes;
    logic          w_unused;

    assign w_unused = ^i_cmd[CW-1:LEN_LSB+LEN_W];

    // The extra borrow bit catches addresses below BASE without a constant compare.
    always_comb begin
        {w_borrow, w_rel} = {1'b0, i_dstaddr} - {1'b0, BASE};
        o_opcode    = i_cmd[OPC_LSB +: OPC_W];
        o_size      = i_cmd[SIZE_LSB +: SIZE_W];
        o_len       = i_cmd[LEN_LSB +: LEN_W];
        w_alignMask = (AW'(1) << o_size) - AW'(1);
        w_inRange   = !w_borrow && (w_rel < SPAN);
        w_aligned   = (i_dstaddr & w_alignMask) == '0;
        o_legal     = (o_len == '0) && (o_size <= MAX_SIZE) && w_aligned && w_inRange;
        o_offset    = w_rel[OB-1:0];
        o_index     = w_rel[OB +: IW];
        w_off       = int'(o_offset);
        w_nbytes    = 1 << o_size;
        for (int b = 0; b < NB; b++) begin
            o_bytemask[b] = (b >= w_off) && (b < w_off + w_nbytes);
        end
    end

endmodule

// File: rtl/ebrick_umi_mem.sv
// UMI device backed by a byte-writable word memory. Reads and writes get one
// response each; posted writes and rejected commands are absorbed silently.
module ebrick_umi_mem
    import ebrick_umi_mem_pkg::*;
#(
    parameter int            DW    = 32,
    parameter int            AW    = 64,
    parameter int            CW    = 32,
    parameter int            DEPTH = 1024,
    parameter logic [AW-1:0] BASE  = '0
) (
    input  logic             clk,
    input  logic             reset,
    ebrick_umi_mem_if.slave  udev,
    output logic [7:0]       err_count
);

    localparam int NB = DW / 8;
    localparam int OB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);

    state_t r_state;
    state_t w_nextState;

    logic [DW-1:0] r_mem [DEPTH];
    logic [CW-1:0] r_respCmd;
    logic [AW-1:0] r_respDst;
    logic [AW-1:0] r_respSrc;
    logic [DW-1:0] r_respData;
    logic [7:0]    r_errCount;

    logic [OPC_W-1:0]  w_opcode;
    logic [SIZE_W-1:0] w_size;
    logic [LEN_W-1:0]  w_len;
    logic [IW-1:0]     w_index;
    logic [OB-1:0]     w_offset;
    logic [NB-1:0]     w_bytemask;
    logic              w_legal;

    logic          w_accept;
    logic          w_isRead;
    logic          w_isWrite;
    logic          w_isPosted;
    logic          w_needResp;
    logic          w_memWe;
    logic          w_reject;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rdRaw;
    logic [DW-1:0] w_rdata;
    int            w_nbytes;

    ebrick_umi_mem_decode #(
        .DW(DW), .AW(AW), .CW(CW), .DEPTH(DEPTH), .BASE(BASE)
    ) u_decode (
        .i_cmd      (udev.udev_req_cmd),
        .i_dstaddr  (udev.udev_req_dstaddr),
        .o_opcode   (w_opcode),
        .o_size     (w_size),
        .o_len      (w_len),
        .o_index    (w_index),
        .o_offset   (w_offset),
        .o_bytemask (w_bytemask),
        .o_legal    (w_legal)
    );

    assign udev.udev_req_ready = (r_state == IDLE) && !reset;

    assign w_accept   = udev.udev_req_valid && udev.udev_req_ready;
    assign w_isRead   = (w_opcode == REQ_READ);
    assign w_isWrite  = (w_opcode == REQ_WRITE);
    assign w_isPosted = (w_opcode == REQ_POSTED);
    assign w_needResp = w_accept && (w_isRead || w_isWrite);
    assign w_memWe    = w_accept && (w_isWrite || w_isPosted) && w_legal;
    assign w_reject   = w_accept && (!(w_isRead || w_isWrite || w_isPosted) || !w_legal);

    // Write data is moved up to the byte offset; read data is moved down and trimmed to size.
    always_comb begin
        w_wdata  = udev.udev_req_data << {w_offset, 3'b000};
        w_rdRaw  = r_mem[w_index] >> {w_offset, 3'b000};
        w_nbytes = 1 << w_size;
        w_rdata  = '0;
        for (int b = 0; b < NB; b++) begin
            if (b < w_nbytes) begin
                w_rdata[b*8 +: 8] = w_rdRaw[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState          = r_state;
        udev.udev_resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_needResp) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                udev.udev_resp_valid = 1'b1;
                if (udev.udev_resp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Response fields only load on acceptance, so they hold while the host stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_respCmd  <= '0;
            r_respDst  <= '0;
            r_respSrc  <= '0;
            r_respData <= '0;
        end else if (w_needResp) begin
            r_respCmd  <= CW'(packRespCmd(w_isRead ? RESP_READ : RESP_WRITE, w_size, w_len));
            r_respDst  <= udev.udev_req_srcaddr;
            r_respSrc  <= udev.udev_req_dstaddr;
            r_respData <= (w_isRead && w_legal) ? w_rdata : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_errCount <= '0;
        end else if (w_reject && (r_errCount != 8'hFF)) begin
            r_errCount <= r_errCount + 8'd1;
        end
    end

    // Storage has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            for (int b = 0; b < NB; b++) begin
                if (w_bytemask[b]) begin
                    r_mem[w_index][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign udev.udev_resp_cmd     = r_respCmd;
    assign udev.udev_resp_dstaddr = r_respDst;
    assign udev.udev_resp_srcaddr = r_respSrc;
    assign udev.udev_resp_data    = r_respData;
    assign err_count              = r_errCount;

endmodule

// File: tb/tb_ebrick_umi_mem.sv
// Scoreboard bench for ebrick_umi_mem: directed scenarios plus randomized
// traffic checked against a byte-array reference model.
module tb_ebrick_umi_mem;

    localparam int DW = 32;
    localparam int AW = 64;
    localparam int CW = 32;
    localparam int MEM_BYTES = 1024 * 4;

    localparam logic [4:0] OP_READ   = 5'h01;
    localparam logic [4:0] OP_RRESP  = 5'h02;
    localparam logic [4:0] OP_WRITE  = 5'h03;
    localparam logic [4:0] OP_WRESP  = 5'h04;
    localparam logic [4:0] OP_POSTED = 5'h05;

    typedef struct {
        logic [31:0] cmd;
        logic [63:0] dst;
        logic [63:0] src;
        logic [31:0] data;
        bit          isRead;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] errCount;

    ebrick_umi_mem_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    ebrick_umi_mem #(
        .DW(DW), .AW(AW), .CW(CW), .DEPTH(1024), .BASE(64'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .udev      (bus),
        .err_count (errCount)
    );

    exp_t        expQ[$];
    exp_t        monE;
    logic [7:0]  refMem [0:MEM_BYTES-1];
    int          errModel;
    int          checks;
    int          errors;
    int          readyMode;
    bit          held;
    logic [31:0] heldCmd;
    logic [63:0] heldDst;
    logic [63:0] heldSrc;
    logic [31:0] heldData;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] mkCmd(input logic [4:0] op, input logic [2:0] size, input logic [7:0] len);
        return {16'h0, len, size, op};
    endfunction

    // Reference model: byte array plus the legality rules in plain arithmetic.
    task automatic modelRequest(input logic [31:0] cmd, input logic [63:0] dst,
                                input logic [63:0] src, input logic [31:0] data);
        logic [4:0]  op;
        logic [2:0]  size;
        logic [7:0]  len;
        int          nbytes;
        bit          legal;
        logic [31:0] rd;
        exp_t        e;
        op     = cmd[4:0];
        size   = cmd[7:5];
        len    = cmd[15:8];
        nbytes = 1 << size;
        legal  = (len == 0) && (size <= 2) && ((dst % nbytes) == 0) && (dst < MEM_BYTES);
        rd     = 32'h0;
        if ((op == OP_WRITE || op == OP_POSTED) && legal) begin
            for (int i = 0; i < nbytes; i++) refMem[int'(dst) + i] = data[8*i +: 8];
        end
        if (op == OP_READ && legal) begin
            for (int i = 0; i < nbytes; i++) rd[8*i +: 8] = refMem[int'(dst) + i];
        end
        if (((op == OP_READ || op == OP_WRITE || op == OP_POSTED) && !legal) ||
            !(op == OP_READ || op == OP_WRITE || op == OP_POSTED)) begin
            if (errModel < 255) errModel++;
        end
        if (op == OP_READ || op == OP_WRITE) begin
            e.cmd    = mkCmd((op == OP_READ) ? OP_RRESP : OP_WRESP, size, len);
            e.dst    = src;
            e.src    = dst;
            e.data   = rd;
            e.isRead = (op == OP_READ);
            expQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] cmd, input logic [63:0] dst,
                                 input logic [63:0] src, input logic [31:0] data);
        int waitCnt;
        @(negedge clk);
        bus.udev_req_cmd     = cmd;
        bus.udev_req_dstaddr = dst;
        bus.udev_req_srcaddr = src;
        bus.udev_req_data    = data;
        bus.udev_req_valid   = 1'b1;
        waitCnt = 0;
        while (!bus.udev_req_ready && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!bus.udev_req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_accept_timeout actual=ready_low required=ready_high");
            bus.udev_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        modelRequest(cmd, dst, src, data);
        #1 bus.udev_req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout actual=%0d required=0", expQ.size());
            expQ.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: chooses resp_ready for the coming edge, then checks what the DUT presents.
    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
            bus.udev_resp_ready = 1'b1;
        end else begin
            case (readyMode)
                0:       bus.udev_resp_ready = 1'b1;
                1:       bus.udev_resp_ready = ($urandom_range(0, 3) != 0);
                default: bus.udev_resp_ready = 1'b0;
            endcase
            if (bus.udev_resp_valid) begin
                checkOutput("req_ready_during_resp", 64'(bus.udev_req_ready), 64'h0);
                if (held) begin
                    checkOutput("hold_cmd", 64'(bus.udev_resp_cmd), 64'(heldCmd));
                    checkOutput("hold_dst", bus.udev_resp_dstaddr, heldDst);
                    checkOutput("hold_src", bus.udev_resp_srcaddr, heldSrc);
                    checkOutput("hold_data", 64'(bus.udev_resp_data), 64'(heldData));
                end
                if (bus.udev_resp_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_resp actual=cmd_%h required=no_response", bus.udev_resp_cmd);
                    end else begin
                        monE = expQ.pop_front();
                        checkOutput("resp_cmd", 64'(bus.udev_resp_cmd), 64'(monE.cmd));
                        checkOutput("resp_dst", bus.udev_resp_dstaddr, monE.dst);
                        checkOutput("resp_src", bus.udev_resp_srcaddr, monE.src);
                        if (monE.isRead) checkOutput("resp_data", 64'(bus.udev_resp_data), 64'(monE.data));
                    end
                end
                held     = !bus.udev_resp_ready;
                heldCmd  = bus.udev_resp_cmd;
                heldDst  = bus.udev_resp_dstaddr;
                heldSrc  = bus.udev_resp_srcaddr;
                heldData = bus.udev_resp_data;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic randomPhase(input int count);
        int          sel;
        logic [4:0]  op;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [63:0] dst;
        int          addrSel;
        int          nbytes;
        for (int i = 0; i < count; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 40)      op = OP_READ;
            else if (sel < 65) op = OP_WRITE;
            else if (sel < 90) op = OP_POSTED;
            else               op = 5'h09;
            size    = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            len     = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            nbytes  = 1 << size;
            addrSel = $urandom_range(0, 19);
            if (addrSel == 0)      dst = 64'h1000 + 64'($urandom_range(0, 255));
            else if (addrSel == 1) dst = 64'($urandom_range(0, 255)) | 64'h1;
            else                   dst = 64'($urandom_range(0, 255)) & ~64'(nbytes - 1);
            applyStimulus(mkCmd(op, size, len), dst, {$urandom, $urandom}, $urandom);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        errModel  = 0;
        readyMode = 0;
        held      = 1'b0;
        reset     = 1'b1;
        bus.udev_req_valid   = 1'b0;
        bus.udev_req_cmd     = '0;
        bus.udev_req_dstaddr = '0;
        bus.udev_req_srcaddr = '0;
        bus.udev_req_data    = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_resp_valid", 64'(bus.udev_resp_valid), 64'h0);
        checkOutput("rst_req_ready", 64'(bus.udev_req_ready), 64'h0);
        checkOutput("rst_err_count", 64'(errCount), 64'h0);
        checkOutput("rst_resp_cmd", 64'(bus.udev_resp_cmd), 64'h0);
        checkOutput("rst_resp_dst", bus.udev_resp_dstaddr, 64'h0);
        checkOutput("rst_resp_data", 64'(bus.udev_resp_data), 64'h0);
        reset = 1'b0;

        for (int w = 0; w < 64; w++) begin
            applyStimulus(mkCmd(OP_POSTED, 3'd2, 8'd0), 64'(w * 4), 64'h0, $urandom);
        end
        waitDrain();

        applyStimulus(mkCmd(OP_WRITE, 3'd2, 8'd0), 64'h10, 64'hABCD_0000, 32'hDEADBEEF);
        applyStimulus(mkCmd(OP_READ, 3'd2, 8'd0), 64'h10, 64'h1234_5678, 32'h0);
        waitDrain();

        applyStimulus(mkCmd(OP_POSTED, 3'd0, 8'd0), 64'h11, 64'h0, 32'h000000AA);
        applyStimulus(mkCmd(OP_READ, 3'd2, 8'd0), 64'h10, 64'h2222, 32'h0);
        waitDrain();

        readyMode = 2;
        applyStimulus(mkCmd(OP_READ, 3'd2, 8'd0), 64'h10, 64'h3333, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("stall_resp_valid", 64'(bus.udev_resp_valid), 64'h1);
            checkOutput("stall_req_ready", 64'(bus.udev_req_ready), 64'h0);
        end
        readyMode = 0;
        waitDrain();

        applyStimulus(mkCmd(OP_READ, 3'd2, 8'd0), 64'h1000, 64'h4444, 32'h0);
        applyStimulus(mkCmd(OP_READ, 3'd2, 8'd0), 64'h12, 64'h5555, 32'h0);
        applyStimulus(mkCmd(5'h09, 3'd2, 8'd0), 64'h10, 64'h6666, 32'h0);
        waitDrain();
        checkOutput("err_after_illegal", 64'(errCount), 64'd3);

        applyStimulus(mkCmd(OP_READ, 3'd2, 8'd0), 64'h10, 64'h7777, 32'h0);
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_in_resp_valid", 64'(bus.udev_resp_valid), 64'h0);
        checkOutput("rst_in_resp_req_ready", 64'(bus.udev_req_ready), 64'h0);
        checkOutput("rst_in_resp_err", 64'(errCount), 64'h0);
        expQ.delete();
        errModel = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(mkCmd(OP_READ, 3'd2, 8'd0), 64'h10, 64'h8888, 32'h0);
        waitDrain();

        readyMode = 1;
        randomPhase(300);
        waitDrain();
        readyMode = 0;
        checkOutput("err_random", 64'(errCount), 64'(errModel));

        for (int k = 0; k < 300; k++) begin
            applyStimulus(mkCmd(5'h09 + 5'($urandom_range(0, 1) * 2), 3'($urandom_range(0, 2)), 8'd0),
                          64'($urandom_range(0, 255)), 64'h0, $urandom);
        end
        waitDrain();
        checkOutput("err_saturate", 64'(errCount), 64'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
